// File: rtl/drum_div_seq.sv
// drum_div_seq: iterative unbiased dynamic-range approximate divider.
// Ports: clk, rst_n, in_valid/in_ready + a, b in; out_valid/out_ready + q, dbz out; busy.
module drum_div_seq #(
    parameter int WIDTH = 8,
    parameter int K     = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic             dbz,
    output logic             busy
);

    localparam int QW = K + WIDTH;
    localparam int EW = $clog2(WIDTH + 1);
    localparam int SW = $clog2(2 * WIDTH + 1);
    localparam int CW = $clog2(QW + 1);
    localparam logic [CW-1:0] LAST = CW'(QW);

    typedef enum logic [1:0] {
        S_IDLE,
        S_NORM,
        S_ITER,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [K-1:0]     ma_q, ma_d;
    logic [K-1:0]     mb_q, mb_d;
    logic [EW-1:0]    ea_q, ea_d;
    logic [EW-1:0]    eb_q, eb_d;
    logic             zb_q, zb_d;
    logic [K:0]       rem_q, rem_d;
    logic [QW-1:0]    quo_q, quo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             dbz_q, dbz_d;

    // Exponent: how far the leading one sits above the K-bit window.
    function automatic logic [EW-1:0] lead_exp(input logic [WIDTH-1:0] x);
        logic [EW-1:0] e;
        e = '0;
        for (int i = K; i < WIDTH; i++) begin
            if (x[i]) e = EW'(i - (K - 1));
        end
        return e;
    endfunction

    // Truncated mantissa; the dropped tail is replaced by a forced 1 (unbiasing).
    function automatic logic [K-1:0] lead_mant(input logic [WIDTH-1:0] x,
                                               input logic [EW-1:0]    e);
        logic [WIDTH-1:0] s;
        s = x >> e;
        if (e != '0) s[0] = 1'b1;
        return s[K-1:0];
    endfunction

    logic [K:0]    rem_sh;
    logic [K:0]    mb_ext;
    logic [SW-1:0] sh;
    logic [QW-1:0] qs;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        ea_d    = ea_q;
        eb_d    = eb_q;
        zb_d    = zb_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        dbz_d   = dbz_q;
        // quo_q doubles as the dividend shifter: its MSB feeds the remainder
        rem_sh  = {rem_q[K-1:0], quo_q[QW-1]};
        mb_ext  = {1'b0, mb_q};
        sh      = SW'(WIDTH) + SW'(eb_q) - SW'(ea_q);
        qs      = quo_q >> sh;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                ea_d    = lead_exp(a_q);
                eb_d    = lead_exp(b_q);
                ma_d    = lead_mant(a_q, ea_d);
                mb_d    = lead_mant(b_q, eb_d);
                zb_d    = (b_q == '0);
                rem_d   = '0;
                quo_d   = {ma_d, {WIDTH{1'b0}}};
                cnt_d   = '0;
                state_d = S_ITER;
            end
            S_ITER: begin
                if (cnt_q == LAST) begin
                    // All quotient bits present: final cycle renormalises.
                    q_d     = zb_q ? {WIDTH{1'b1}} : qs[WIDTH-1:0];
                    dbz_d   = zb_q;
                    state_d = S_DONE;
                end else begin
                    if (rem_sh >= mb_ext) begin
                        rem_d = rem_sh - mb_ext;
                        quo_d = {quo_q[QW-2:0], 1'b1};
                    end else begin
                        rem_d = rem_sh;
                        quo_d = {quo_q[QW-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            ea_q    <= '0;
            eb_q    <= '0;
            zb_q    <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            zb_q    <= zb_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign q         = q_q;
    assign dbz       = dbz_q;

endmodule
